// File: rtl/page_rank.sv
// Iterative fixed-point PageRank engine: computes one destination row per clock
// from the committed ranks and commits a whole new rank vector every N clocks.
module page_rank #(
  parameter int N     = 16,
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*N-1:0]       adj,
  input  logic [N*WIDTH-1:0]   nodeWeight,
  output logic [WIDTH-1:0]     node0Val
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = WIDTH + CW;

  localparam logic [WIDTH:0]   FULL = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0]   NDIV = (WIDTH + 1)'(N);
  localparam logic [WIDTH-1:0] INIT = (N == 1) ? {WIDTH{1'b1}} : WIDTH'(FULL / NDIV);
  localparam logic [CW-1:0]    LAST = CW'(N - 1);
  localparam logic [SW-1:0]    SAT  = SW'({WIDTH{1'b1}});

  logic [WIDTH-1:0] rank      [N];
  logic [WIDTH-1:0] next_rank [N];
  logic [WIDTH-1:0] term      [N];
  logic [CW-1:0]    cnt;
  logic [N-1:0]     row_adj;
  logic [SW-1:0]    sum;
  logic [WIDTH-1:0] row_val;

  // Full-precision product, keeping only the upper WIDTH bits (fraction * fraction).
  function automatic logic [WIDTH-1:0] scale(input logic [WIDTH-1:0] r,
                                             input logic [WIDTH-1:0] w);
    logic [2*WIDTH-1:0] p;
    p = (2*WIDTH)'(r) * (2*WIDTH)'(w);
    return p[2*WIDTH-1:WIDTH];
  endfunction

  assign row_adj = adj[int'(cnt)*N +: N];

  // NOTE: sum is assigned a default before the loop so no latch is inferred, and
  // blocking assignments are used here because each addition feeds the next.
  always_comb begin
    sum = '0;
    for (int j = 0; j < N; j++) begin
      term[j] = scale(rank[j], nodeWeight[j*WIDTH +: WIDTH]);
      if (row_adj[j]) sum = sum + SW'(term[j]);
    end
    row_val = (sum > SAT) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  end

  // NOTE: the rank arrays are plain flops and must be reset, since every run
  // starts from the uniform INIT distribution rather than from whatever was left.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      node0Val <= INIT;
      for (int k = 0; k < N; k++) begin
        rank[k]      <= INIT;
        next_rank[k] <= INIT;
      end
    end else begin
      next_rank[cnt] <= row_val;
      if (cnt == LAST) begin
        cnt <= '0;
        // Commit includes the row being produced on this same edge.
        for (int k = 0; k < N; k++)
          rank[k] <= (CW'(k) == cnt) ? row_val : next_rank[k];
        node0Val <= (cnt == '0) ? row_val : next_rank[0];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_page_rank.sv
// Self-checking bench for page_rank: a whole-iteration Jacobi model predicts
// node0Val every cycle, plus directed literal checks for the known cases.
module tb_page_rank;

  localparam int N = 16;
  localparam int W = 16;
  localparam logic [W-1:0] INIT = 16'h1000;
  localparam longint unsigned MAXV = (64'd1 << W) - 1;

  logic             clk;
  logic             reset;
  logic [N*N-1:0]   adj;
  logic [N*W-1:0]   nodeWeight;
  logic [W-1:0]     node0Val;

  int checks = 0;
  int errors = 0;

  longint unsigned mrank [N];
  int              edge_n;
  logic [W-1:0]    exp_val;

  page_rank #(.N(N), .WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .adj        (adj),
    .nodeWeight (nodeWeight),
    .node0Val   (node0Val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic longint unsigned wt(input int j);
    logic [W-1:0] w;
    w = nodeWeight[j*W +: W];
    return longint'(w);
  endfunction

  // Reference: after every N clocks, replace the whole rank vector at once.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) mrank[k] = 64'(INIT);
      edge_n  = 0;
      exp_val = INIT;
    end else begin
      edge_n++;
      if (edge_n % N == 0) begin
        longint unsigned nr [N];
        for (int i = 0; i < N; i++) begin
          longint unsigned s;
          s = 0;
          for (int j = 0; j < N; j++)
            if (adj[i*N + j]) s += (mrank[j] * wt(j)) >> W;
          nr[i] = (s > MAXV) ? MAXV : s;
        end
        for (int k = 0; k < N; k++) mrank[k] = nr[k];
        exp_val = W'(mrank[0]);
      end
    end
  end

  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      if (reset === 1'b1) check("reset_hold", node0Val, INIT);
    end else begin
      check("model", node0Val, exp_val);
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    #1 check("reset_async", node0Val, INIT);
    repeat (2) @(posedge clk);
    #1 check("reset_after_edge", node0Val, INIT);
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pattern_weights();
    for (int j = 0; j < N; j++)
      case (j % 4)
        0: nodeWeight[j*W +: W] = 16'h5555;
        1: nodeWeight[j*W +: W] = 16'h8000;
        2: nodeWeight[j*W +: W] = 16'hFFFF;
        default: nodeWeight[j*W +: W] = 16'h8000;
      endcase
  endtask

  initial begin
    int sparse_bits [14] = '{45, 46, 75, 81, 96, 113, 129, 131, 132, 137, 138, 140, 230, 245};
    reset      = 1'b0;
    adj        = '0;
    nodeWeight = '0;
    #1;

    // Power-on: hold INIT through the first 15 edges.
    for (int j = 0; j < N; j++) nodeWeight[j*W +: W] = 16'hFFFF;
    adj[0] = 1'b1;
    adj[17] = 1'b1;
    do_reset();
    for (int e = 1; e < N; e++) begin
      wait_edges(1);
      check("poweron_hold", node0Val, INIT);
    end

    // Sparse graph with empty row 0.
    adj = '0;
    foreach (sparse_bits[b]) adj[sparse_bits[b]] = 1'b1;
    set_pattern_weights();
    do_reset();
    wait_edges(16);
    check("sparse_it1", node0Val, 16'h0000);
    wait_edges(16);
    check("sparse_it2", node0Val, 16'h0000);

    // Self-loop on node 0.
    adj = '0;
    adj[0] = 1'b1;
    nodeWeight = '0;
    nodeWeight[0 +: W] = 16'hFFFF;
    do_reset();
    wait_edges(16);
    check("selfloop_it1", node0Val, 16'h0FFF);
    wait_edges(16);
    check("selfloop_it2", node0Val, 16'h0FFE);

    // Single predecessor with no inputs of its own.
    adj = '0;
    adj[1] = 1'b1;
    nodeWeight = '0;
    nodeWeight[W +: W] = 16'h8000;
    do_reset();
    wait_edges(15);
    check("single_hold", node0Val, INIT);
    wait_edges(1);
    check("single_it1", node0Val, 16'h0800);
    wait_edges(16);
    check("single_it2", node0Val, 16'h0000);

    // Saturation.
    adj = '1;
    for (int j = 0; j < N; j++) nodeWeight[j*W +: W] = 16'hFFFF;
    do_reset();
    wait_edges(16);
    check("sat_it1", node0Val, 16'hFFF0);
    wait_edges(16);
    check("sat_it2", node0Val, 16'hFFFF);
    wait_edges(16);
    check("sat_it3", node0Val, 16'hFFFF);

    // Reset mid-run on the self-loop case.
    adj = '0;
    adj[0] = 1'b1;
    nodeWeight = '0;
    nodeWeight[0 +: W] = 16'hFFFF;
    do_reset();
    wait_edges(20);
    check("midrun_pre", node0Val, 16'h0FFF);
    #2;
    do_reset();
    wait_edges(15);
    check("midrun_hold", node0Val, INIT);
    wait_edges(1);
    check("midrun_it1", node0Val, 16'h0FFF);

    // Randomized graphs and weights against the model.
    for (int t = 0; t < 8; t++) begin
      for (int b = 0; b < N*N; b++) adj[b] = ($urandom_range(0, 3) == 0);
      for (int j = 0; j < N; j++)
        nodeWeight[j*W +: W] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : W'($urandom);
      do_reset();
      wait_edges(4*N + $urandom_range(0, N-1));
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
